// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM (Moore style).
// Sequences PC, IR, register-file, memory and ALU-operand controls for
// lw, sw, R-type, beq, addi and j. Every memory access waits on mem_ready.
// aluop feeds the ALU decoder's aluop input (00=add, 01=sub, 10=funct).
// Optional build macro MIPS_MC_BNE_EN adds bne (opcode 000101) via BNEEX.
module mips_mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`ifdef MIPS_MC_BNE_EN
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
`else
        S_JEX     = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t state_q;
    state_t state_d;

    // Raw strobes before the reset gate.
    logic pc_write;
    logic branch;
`ifdef MIPS_MC_BNE_EN
    logic branch_ne;
`endif
    logic pc_load;
    logic ir_load;
    logic rf_write;
    logic mem_write;

    // State register; reset forces FETCH immediately.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs decoded from the current state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned -- otherwise synthesis infers a latch.
        state_d   = S_FETCH;
        pc_write  = 1'b0;
        branch    = 1'b0;
`ifdef MIPS_MC_BNE_EN
        branch_ne = 1'b0;
`endif
        ir_load   = 1'b0;
        rf_write  = 1'b0;
        mem_write = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        iord      = 1'b0;
        memtoreg  = 1'b0;
        regdst    = 1'b0;
        pcsrc     = 2'b00;
        aluop     = 2'b00;
        illegal   = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 computed by the ALU while the instruction is read.
                alusrcb  = 2'b01;
                ir_load  = mem_ready;
                pc_write = mem_ready;
                state_d  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut.
                alusrcb = 2'b11;
                case (op)
                    OP_LW,
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_RTYPEEX;
                    OP_BEQ:   state_d = S_BEQEX;
                    OP_ADDI:  state_d = S_ADDIEX;
                    OP_J:     state_d = S_JEX;
`ifdef MIPS_MC_BNE_EN
                    OP_BNE:   state_d = S_BNEEX;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                // IR is held, so op still distinguishes lw from sw here.
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                rf_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe stays high for the whole memory wait.
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                rf_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcsrc    = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
`ifdef MIPS_MC_BNE_EN
            S_BNEEX: begin
                alusrca   = 1'b1;
                aluop     = 2'b01;
                pcsrc     = 2'b01;
                branch_ne = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: begin
                // Unused encodings recover to FETCH with all outputs low.
                state_d = S_FETCH;
            end
        endcase
    end

    // PC load combines unconditional writes with taken branches.
`ifdef MIPS_MC_BNE_EN
    assign pc_load = pc_write | (branch & zero) | (branch_ne & ~zero);
`else
    assign pc_load = pc_write | (branch & zero);
`endif

    // Architectural write strobes are suppressed while reset is held, so an
    // abandoned instruction (or a FETCH seen during reset) never updates
    // PC, IR, registers or memory.
    assign pcen     = pc_load   & ~reset;
    assign irwrite  = ir_load   & ~reset;
    assign regwrite = rf_write  & ~reset;
    assign memwrite = mem_write & ~reset;

    assign state = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Testbench for mips_mc_ctrl: hand-written control-word sequences, a table
// of per-instruction state traces, and randomized instruction streams
// checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pcen, memwrite, irwrite, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       iord, memtoreg, regdst;
    logic [1:0] pcsrc, aluop;
    logic       illegal;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mips_mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcen      (pcen),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .iord      (iord),
        .memtoreg  (memtoreg),
        .regdst    (regdst),
        .pcsrc     (pcsrc),
        .aluop     (aluop),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Control word order: pcen memwrite irwrite regwrite alusrca alusrcb
    // iord memtoreg regdst pcsrc aluop illegal.
    function automatic logic [14:0] ctrl_now();
        return {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
                iord, memtoreg, regdst, pcsrc, aluop, illegal};
    endfunction

    function automatic logic [14:0] cw(input logic pc, input logic mw, input logic ir,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic io, input logic m2r, input logic rd,
                                       input logic [1:0] pcs, input logic [1:0] aop,
                                       input logic ill);
        return {pc, mw, ir, rw, asa, asb, io, m2r, rd, pcs, aop, ill};
    endfunction

    // One clock of a hand sequence: drive, settle, compare, advance to next negedge.
    task automatic hc(input string name, input logic mr, input logic zr,
                      input logic [3:0] es, input logic [14:0] ec);
        mem_ready = mr;
        zero      = zr;
        #1;
        check({name, " state"}, state, es);
        check({name, " ctrl"}, ctrl_now(), ec);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Table of per-instruction traces: path nibbles MSB-first, index 3 is
    // repeated once per memory wait cycle.
    typedef struct packed {
        logic [5:0]  op;
        logic        zr;
        logic [3:0]  waits;
        logic [3:0]  base;
        logic [23:0] path;
    } vec_t;

    function automatic vec_t mkv(input logic [5:0] o, input logic z, input int w,
                                 input int b, input logic [23:0] p);
        vec_t r;
        r.op    = o;
        r.zr    = z;
        r.waits = 4'(w);
        r.base  = 4'(b);
        r.path  = p;
        return r;
    endfunction

    localparam int NV = 12;
    vec_t vecs [NV];

    // Instruction-level reference model for the random stream.
    typedef enum int {C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_BNE, C_ILL} cls_t;
    cls_t       rcls;
    int         rn;
    logic [3:0] rp [0:4];

    function automatic cls_t class_of(input logic [5:0] o);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
`ifdef MIPS_MC_BNE_EN
            6'b000101: return C_BNE;
`endif
            default:   return C_ILL;
        endcase
    endfunction

    task automatic pick_instr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000000;
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            6: op = 6'b000101;
            9: op = 6'b111111;
            default: op = 6'($urandom_range(0, 63));
        endcase
        rcls  = class_of(op);
        // Every instruction starts with fetch (0) and decode (1).
        rp[0] = 4'd0;
        rp[1] = 4'd1;
        rp[2] = 4'd0;
        rp[3] = 4'd0;
        rp[4] = 4'd0;
        case (rcls)
            C_LW:   begin rn = 5; rp[2] = 4'd2; rp[3] = 4'd3; rp[4] = 4'd4; end
            C_SW:   begin rn = 4; rp[2] = 4'd2; rp[3] = 4'd5; end
            C_R:    begin rn = 4; rp[2] = 4'd6; rp[3] = 4'd7; end
            C_BEQ:  begin rn = 3; rp[2] = 4'd8; end
            C_ADDI: begin rn = 4; rp[2] = 4'd9; rp[3] = 4'd10; end
            C_J:    begin rn = 3; rp[2] = 4'd11; end
            C_BNE:  begin rn = 3; rp[2] = 4'd12; end
            default: rn = 2;
        endcase
    endtask

    logic [14:0] c_fetch, c_fetchw, c_decode, c_dec_ill, c_memadr, c_memrd, c_memwb;
    logic [14:0] c_memwr, c_rex, c_rwb, c_beq1, c_beq0, c_addiex, c_addiwb, c_jex, c_bne0;

    int   pi;
    int   idx;
    logic mr, zr, last, waiting;
    logic e_pc, e_ir, e_rw, e_mw, e_ill;

    initial begin
        c_fetch   = cw(1, 0, 1, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0);
        c_fetchw  = cw(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0);
        c_decode  = cw(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0);
        c_dec_ill = cw(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 1);
        c_memadr  = cw(0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0);
        c_memrd   = cw(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0);
        c_memwb   = cw(0, 0, 0, 1, 0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0);
        c_memwr   = cw(0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0);
        c_rex     = cw(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00, 2'b10, 0);
        c_rwb     = cw(0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0);
        c_beq1    = cw(1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b01, 2'b01, 0);
        c_beq0    = cw(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b01, 2'b01, 0);
        c_addiex  = cw(0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0);
        c_addiwb  = cw(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        c_jex     = cw(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 2'b00, 0);
        c_bne0    = cw(1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b01, 2'b01, 0);

        vecs[0]  = mkv(6'b100011, 0, 0, 5, 24'h012340);  // lw
        vecs[1]  = mkv(6'b100011, 0, 2, 5, 24'h012340);  // lw, 2 waits
        vecs[2]  = mkv(6'b101011, 0, 0, 4, 24'h012500);  // sw
        vecs[3]  = mkv(6'b101011, 1, 3, 4, 24'h012500);  // sw, 3 waits
        vecs[4]  = mkv(6'b000000, 0, 0, 4, 24'h016700);  // R-type
        vecs[5]  = mkv(6'b000100, 1, 0, 3, 24'h018000);  // beq taken
        vecs[6]  = mkv(6'b000100, 0, 0, 3, 24'h018000);  // beq not taken
        vecs[7]  = mkv(6'b001000, 0, 0, 4, 24'h019A00);  // addi
        vecs[8]  = mkv(6'b000010, 0, 0, 3, 24'h01B000);  // j
        vecs[9]  = mkv(6'b111111, 0, 0, 2, 24'h010000);  // illegal
`ifdef MIPS_MC_BNE_EN
        vecs[10] = mkv(6'b000101, 0, 0, 3, 24'h01C000);  // bne
`else
        vecs[10] = mkv(6'b000101, 0, 0, 2, 24'h010000);  // bne absent -> illegal
`endif
        vecs[11] = mkv(6'b001111, 0, 0, 2, 24'h010000);  // lui unsupported

        // Reset state.
        reset     = 1'b1;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset state", state, 0);
        check("reset regwrite", regwrite, 0);
        check("reset pcen", pcen, 0);
        reset = 1'b0;
        #1;
        check("post-reset fetch ctrl", ctrl_now(), c_fetch);
        @(posedge clk);
        @(negedge clk);
        // Now in DECODE with op=R-type: walk into RTYPEEX, then reset mid-instruction.
        hc("rst dec", 1, 0, 4'd1, c_decode);
        mem_ready = 1'b1;
        #1;
        check("rst rex state", state, 6);
        check("rst rex ctrl", ctrl_now(), c_rex);
        #1;
        reset = 1'b1;
        #1;
        check("async reset state", state, 0);
        check("async reset regwrite", regwrite, 0);
        check("async reset memwrite", memwrite, 0);
        check("async reset pcen", pcen, 0);
        check("async reset irwrite", irwrite, 0);
        @(posedge clk);
        #1;
        check("held reset state", state, 0);
        check("held reset regwrite", regwrite, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release irwrite", irwrite, 1);
        check("release pcen", pcen, 1);
        @(posedge clk);
        #1;
        check("release to decode", state, 1);
        @(negedge clk);
        hc("rst2 dec", 1, 0, 4'd1, c_decode);
        hc("rst2 rex", 1, 0, 4'd6, c_rex);
        hc("rst2 rwb", 1, 0, 4'd7, c_rwb);

        // lw with one fetch wait.
        op = 6'b100011;
        hc("lw fetchw", 0, 0, 4'd0, c_fetchw);
        hc("lw fetch", 1, 0, 4'd0, c_fetch);
        hc("lw dec", 1, 0, 4'd1, c_decode);
        hc("lw memadr", 1, 0, 4'd2, c_memadr);
        hc("lw memrd", 1, 0, 4'd3, c_memrd);
        hc("lw memwb", 1, 0, 4'd4, c_memwb);

        // sw with three wait cycles in MEMWR.
        op = 6'b101011;
        hc("sw fetch", 1, 0, 4'd0, c_fetch);
        hc("sw dec", 1, 0, 4'd1, c_decode);
        hc("sw memadr", 1, 0, 4'd2, c_memadr);
        for (int i = 0; i < 3; i++) hc($sformatf("sw memwr wait%0d", i), 0, 0, 4'd5, c_memwr);
        hc("sw memwr done", 1, 0, 4'd5, c_memwr);

        // R-type.
        op = 6'b000000;
        hc("r fetch", 1, 0, 4'd0, c_fetch);
        hc("r dec", 1, 0, 4'd1, c_decode);
        hc("r rex", 1, 0, 4'd6, c_rex);
        hc("r rwb", 1, 0, 4'd7, c_rwb);

        // beq taken / not taken, j, addi.
        op = 6'b000100;
        hc("beq1 fetch", 1, 1, 4'd0, c_fetch);
        hc("beq1 dec", 1, 1, 4'd1, c_decode);
        hc("beq1 ex", 1, 1, 4'd8, c_beq1);
        hc("beq0 fetch", 1, 0, 4'd0, c_fetch);
        hc("beq0 dec", 1, 0, 4'd1, c_decode);
        hc("beq0 ex", 1, 0, 4'd8, c_beq0);
        op = 6'b000010;
        hc("j fetch", 1, 0, 4'd0, c_fetch);
        hc("j dec", 1, 0, 4'd1, c_decode);
        hc("j ex", 1, 0, 4'd11, c_jex);
        op = 6'b001000;
        hc("addi fetch", 1, 0, 4'd0, c_fetch);
        hc("addi dec", 1, 0, 4'd1, c_decode);
        hc("addi ex", 1, 0, 4'd9, c_addiex);
        hc("addi wb", 1, 0, 4'd10, c_addiwb);

        // Unsupported opcode: illegal pulses only in DECODE.
        op = 6'b111111;
        hc("ill fetch", 1, 0, 4'd0, c_fetch);
        hc("ill dec", 1, 0, 4'd1, c_dec_ill);
        hc("ill after", 0, 0, 4'd0, c_fetchw);

        // bne opcode.
        op = 6'b000101;
        hc("bne fetch", 1, 0, 4'd0, c_fetch);
`ifdef MIPS_MC_BNE_EN
        hc("bne dec", 1, 0, 4'd1, c_decode);
        hc("bne ex", 1, 0, 4'd12, c_bne0);
`else
        hc("bne dec", 1, 0, 4'd1, c_dec_ill);
        hc("bne after", 0, 0, 4'd0, c_fetchw);
`endif

        // Table-driven state traces.
        for (int v = 0; v < NV; v++) begin
            op = vecs[v].op;
            for (int c = 0; c < int'(vecs[v].base) + int'(vecs[v].waits); c++) begin
                mem_ready = !(c >= 3 && c < 3 + int'(vecs[v].waits));
                zero      = vecs[v].zr;
                #1;
                if (c < 3) pi = c;
                else if (c < 3 + int'(vecs[v].waits)) pi = 3;
                else pi = c - int'(vecs[v].waits);
                check($sformatf("vec%0d cyc%0d state", v, c), state, vecs[v].path[(5 - pi) * 4 +: 4]);
                @(posedge clk);
                @(negedge clk);
            end
            #1;
            check($sformatf("vec%0d end state", v), state, 0);
        end

        // Randomized instruction stream against the reference model.
        pick_instr();
        idx = 0;
        for (int c = 0; c < 2000; c++) begin
            mr        = ($urandom_range(0, 3) != 0);
            zr        = 1'($urandom_range(0, 1));
            mem_ready = mr;
            zero      = zr;
            #1;
            last  = (idx == rn - 1);
            e_ir  = (idx == 0) && mr;
            e_pc  = e_ir || (last && ((rcls == C_J) || (rcls == C_BEQ && zr) ||
                                      (rcls == C_BNE && !zr)));
            e_rw  = last && (rcls == C_LW || rcls == C_R || rcls == C_ADDI);
            e_mw  = (rcls == C_SW) && (idx == 3);
            e_ill = (rcls == C_ILL) && (idx == 1);
            check($sformatf("rnd%0d state", c), state, rp[idx]);
            check($sformatf("rnd%0d pcen", c), pcen, e_pc);
            check($sformatf("rnd%0d irwrite", c), irwrite, e_ir);
            check($sformatf("rnd%0d regwrite", c), regwrite, e_rw);
            check($sformatf("rnd%0d memwrite", c), memwrite, e_mw);
            check($sformatf("rnd%0d illegal", c), illegal, e_ill);
            waiting = ((idx == 0) || (idx == 3 && (rcls == C_LW || rcls == C_SW))) && !mr;
            @(posedge clk);
            @(negedge clk);
            if (!waiting) begin
                idx++;
                if (idx == rn) begin
                    pick_instr();
                    idx = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
